// File: rtl/prbs15_burst_controller.sv
// Burst sequencer for a PRBS15 generator: captures seed and length on start,
// issues a one-cycle load, then enables the generator for a counted, pausable, abortable burst.
module prbs15_burst_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [14:0]      seed,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             pause,
  input  logic             abort,
  output logic             gen_load,
  output logic             gen_enable,
  output logic [14:0]      gen_seed,
  output logic             byte_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             seed_err,
  output logic [CNT_W-1:0] bytes_sent
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] remaining_dec;
  logic             gen_load_q, gen_load_d;
  logic             gen_enable_q, gen_enable_d;
  logic [14:0]      gen_seed_q, gen_seed_d;
  logic             byte_valid_q, byte_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             seed_err_q, seed_err_d;
  logic [CNT_W-1:0] bytes_sent_q, bytes_sent_d;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    gen_load_d   = gen_load_q;
    gen_enable_d = gen_enable_q;
    gen_seed_d   = gen_seed_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    seed_err_d   = seed_err_q;
    // Generator output is registered, so a byte enabled now is valid next cycle.
    byte_valid_d = gen_enable_q;
    if (gen_enable_q && (bytes_sent_q != CNT_MAX)) begin
      bytes_sent_d = bytes_sent_q + CNT_ONE;
    end else begin
      bytes_sent_d = bytes_sent_q;
    end
    if (gen_enable_q && (remaining_q != CNT_ZERO)) begin
      remaining_dec = remaining_q - CNT_ONE;
    end else begin
      remaining_dec = remaining_q;
    end

    case (state_q)
      ST_IDLE: begin
        gen_load_d   = 1'b0;
        gen_enable_d = 1'b0;
        busy_d       = 1'b0;
        if (start) begin
          if (seed == 15'd0) begin
            // An all-zero seed would lock the LFSR; reject without touching the generator.
            seed_err_d = 1'b1;
            aborted_d  = 1'b0;
            done_d     = 1'b1;
          end else if (burst_len == CNT_ZERO) begin
            done_d       = 1'b1;
            seed_err_d   = 1'b0;
            aborted_d    = 1'b0;
            bytes_sent_d = CNT_ZERO;
          end else begin
            gen_seed_d   = seed;
            remaining_d  = burst_len;
            bytes_sent_d = CNT_ZERO;
            seed_err_d   = 1'b0;
            aborted_d    = 1'b0;
            gen_load_d   = 1'b1;
            busy_d       = 1'b1;
            state_d      = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          gen_load_d   = 1'b0;
          gen_enable_d = 1'b0;
          done_d       = 1'b1;
          aborted_d    = 1'b1;
          busy_d       = 1'b0;
          remaining_d  = CNT_ZERO;
          state_d      = ST_IDLE;
        end else begin
          gen_load_d   = 1'b0;
          gen_enable_d = ~pause;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          gen_load_d   = 1'b0;
          gen_enable_d = 1'b0;
          done_d       = 1'b1;
          aborted_d    = 1'b1;
          busy_d       = 1'b0;
          remaining_d  = CNT_ZERO;
          state_d      = ST_IDLE;
        end else if (gen_enable_q && (remaining_q == CNT_ONE)) begin
          gen_enable_d = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          remaining_d  = CNT_ZERO;
          state_d      = ST_IDLE;
        end else begin
          remaining_d  = remaining_dec;
          gen_enable_d = ~pause & (remaining_dec != CNT_ZERO);
          state_d      = ST_RUN;
        end
      end

      default: begin
        gen_load_d   = 1'b0;
        gen_enable_d = 1'b0;
        busy_d       = 1'b0;
        remaining_d  = CNT_ZERO;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= CNT_ZERO;
      gen_load_q   <= 1'b0;
      gen_enable_q <= 1'b0;
      gen_seed_q   <= 15'd0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      seed_err_q   <= 1'b0;
      bytes_sent_q <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      gen_load_q   <= gen_load_d;
      gen_enable_q <= gen_enable_d;
      gen_seed_q   <= gen_seed_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      seed_err_q   <= seed_err_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  assign gen_load   = gen_load_q;
  assign gen_enable = gen_enable_q;
  assign gen_seed   = gen_seed_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign seed_err   = seed_err_q;
  assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_prbs15_burst_controller.sv
// Scoreboard bench for prbs15_burst_controller: a burst-level model predicts load,
// byte and completion events from the pause/abort schedule; a monitor checks them.
module tb_prbs15_burst_controller;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset, start, pause, abort;
  logic [14:0]      seed;
  logic [CNT_W-1:0] burst_len;
  logic             gen_load, gen_enable, byte_valid, busy, done, aborted, seed_err;
  logic [14:0]      gen_seed;
  logic [CNT_W-1:0] bytes_sent;

  prbs15_burst_controller #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed), .burst_len(burst_len),
    .pause(pause), .abort(abort), .gen_load(gen_load), .gen_enable(gen_enable),
    .gen_seed(gen_seed), .byte_valid(byte_valid), .busy(busy), .done(done),
    .aborted(aborted), .seed_err(seed_err), .bytes_sent(bytes_sent)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int at; int val; } ev_t;
  typedef struct { int at; int bs; int ab; int se; int sd; } done_t;

  ev_t   load_q[$];
  ev_t   byte_q[$];
  done_t done_q[$];
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;
  bit    prev_load = 1'b0;
  ev_t   m_ev;
  done_t m_dn;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a load, byte or done.
  always @(negedge clock) begin
    if (mon_en) begin
      if (gen_load) begin
        if (prev_load) unexpected("load_twice");
        if (load_q.size() == 0) unexpected("load_extra");
        else begin
          m_ev = load_q.pop_front();
          chk("load_cycle", cyc, m_ev.at);
          chk("load_seed", int'(gen_seed), m_ev.val);
        end
      end
      prev_load = gen_load;
      if (byte_valid) begin
        if (byte_q.size() == 0) unexpected("byte_extra");
        else begin
          m_ev = byte_q.pop_front();
          chk("byte_cycle", cyc, m_ev.at);
        end
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done_extra");
        else begin
          m_dn = done_q.pop_front();
          chk("done_cycle", cyc, m_dn.at);
          chk("done_aborted", int'(aborted), m_dn.ab);
          chk("done_seed_err", int'(seed_err), m_dn.se);
          chk("done_busy", int'(busy), 0);
          if (m_dn.bs >= 0) chk("done_bytes_sent", int'(bytes_sent), m_dn.bs);
          if (m_dn.sd >= 0) chk("done_gen_seed", int'(gen_seed), m_dn.sd);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gen_load"}, int'(gen_load), 0);
    chk({tag, "_gen_enable"}, int'(gen_enable), 0);
    chk({tag, "_gen_seed"}, int'(gen_seed), 0);
    chk({tag, "_byte_valid"}, int'(byte_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_aborted"}, int'(aborted), 0);
    chk({tag, "_seed_err"}, int'(seed_err), 0);
    chk({tag, "_bytes_sent"}, int'(bytes_sent), 0);
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause on edges 4..6; abort_in -1 picks randomly.
  // Edge j is counted from the edge that samples start (j=0). A byte is enabled for each of
  // the first n edges j>=1 whose sampled pause is low, and shows as byte_valid after edge j+1.
  task automatic run_burst(input logic [14:0] sd, input int n, input int pmode,
                           input int abort_in, input int rst_at, input bit noise);
    bit    pz[256];
    int    en_j[$];
    int    jn, e0, end_j, cnt, ab, nab;
    ev_t   ev;
    done_t dn;
    jn = 0;
    for (int j = 0; j < 256; j++) begin
      pz[j] = 1'b0;
      if (pmode == 1 && j < 200) pz[j] = ($urandom_range(0, 3) == 0);
      if (pmode == 2 && j >= 4 && j <= 6) pz[j] = 1'b1;
    end
    cnt = 0;
    for (int j = 1; j < 256 && cnt < n; j++) begin
      if (!pz[j]) begin
        cnt++;
        en_j.push_back(j);
        jn = j;
      end
    end
    ab = abort_in;
    if (ab < 0) ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, jn + 1)) : 0;

    @(negedge clock);
    e0 = cyc + 1;
    start = 1'b1;
    seed = sd;
    burst_len = CNT_W'(n);
    pause = pz[0];
    abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end_j = 0;
    if (sd == 15'd0) begin
      dn = '{e0, -1, 0, 1, -1};
      done_q.push_back(dn);
    end else if (n == 0) begin
      dn = '{e0, 0, 0, 0, -1};
      done_q.push_back(dn);
    end else begin
      ev = '{e0, int'(sd)};
      load_q.push_back(ev);
      nab = 0;
      foreach (en_j[k]) begin
        if ((ab == 0 || en_j[k] < ab) && (rst_at == 0 || en_j[k] + 1 < rst_at)) begin
          ev = '{e0 + en_j[k] + 1, 1};
          byte_q.push_back(ev);
          nab++;
        end
      end
      if (rst_at > 0) end_j = rst_at;
      else if (ab > 0) begin
        dn = '{e0 + ab, nab, 1, 0, int'(sd)};
        done_q.push_back(dn);
        end_j = ab;
      end else begin
        dn = '{e0 + jn + 1, n, 0, 0, int'(sd)};
        done_q.push_back(dn);
        end_j = jn + 1;
      end
    end

    for (int j = 1; j <= end_j; j++) begin
      @(negedge clock);
      if (j == rst_at) begin
        chk("busy_before_reset", int'(busy), 1);
        chk("seed_held_while_busy", int'(gen_seed), int'(sd));
      end
      start = noise && ($urandom_range(0, 3) == 0);
      seed = 15'($urandom);
      burst_len = CNT_W'($urandom_range(1, 40));
      pause = pz[j];
      abort = (j == ab);
      reset = (j == rst_at);
    end
    if (rst_at > 0) begin
      @(negedge clock);
      chk_all_zero("after_reset");
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] rs;
    reset = 1'b1;
    start = 1'b0;
    seed = 15'd0;
    burst_len = {CNT_W{1'b0}};
    pause = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset_state");
    mon_en = 1'b1;
    reset = 1'b0;

    run_burst(15'h7FFF, 2, 0, 0, 0, 1'b0);
    run_burst(15'h0000, 5, 0, 0, 0, 1'b0);
    run_burst(15'h1234, 0, 0, 0, 0, 1'b0);
    run_burst(15'h2ACE, 10, 2, 0, 0, 1'b0);
    run_burst(15'h1357, 100, 0, 7, 0, 1'b0);
    run_burst(15'h0001, 12, 0, 0, 0, 1'b0);
    run_burst(15'h4321, 50, 0, 0, 10, 1'b1);
    run_burst(15'h0ABC, 3, 0, 1, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      rs = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom);
      run_burst(rs, int'($urandom_range(0, 30)), 1, -1, 0, 1'b1);
    end

    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    repeat (5) @(negedge clock);
    chk("pending_loads", load_q.size(), 0);
    chk("pending_bytes", byte_q.size(), 0);
    chk("pending_dones", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
